// File: rtl/sram_controller_if.sv
// MEM-stage side of the SRAM controller: 32-bit load/store request and
// registered response with a ready/freeze handshake.
interface sram_controller_if;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (
    output wr_en, rd_en, address, write_data,
    input  read_data, ready
  );

  modport slave (
    input  wr_en, rd_en, address, write_data,
    output read_data, ready
  );
endinterface

// File: rtl/sram_controller.sv
// Serves 32-bit MEM-stage loads/stores from a 16-bit asynchronous SRAM as a
// low halfword phase followed by a high halfword phase; all pin outputs registered.
module sram_controller #(
  parameter int ADDR_BASE    = 1024,
  parameter int PHASE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  sram_controller_if.slave   mem,
  output logic [17:0]        sram_addr,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_we_n,
  output logic               sram_oe_n
);

  localparam int CW = (PHASE_CYCLES > 2) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PHASE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t        state_reg;
  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_inc;
  logic          op_wr_reg;
  logic [16:0]   word_reg;
  logic [31:0]   wdata_reg;
  logic [31:0]   read_data_reg;
  logic [17:0]   sram_addr_reg;
  logic [15:0]   dq_out_reg;
  logic          dq_oe_reg;
  logic          we_n_reg;
  logic          oe_n_reg;

  logic          req;
  logic [16:0]   word_idx;

  assign req      = mem.wr_en | mem.rd_en;
  // Halfword-pair index; anything outside the SRAM wraps by truncation.
  assign word_idx = 17'((mem.address - 32'(ADDR_BASE)) >> 2);
  assign cnt_inc  = cnt_reg + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      op_wr_reg     <= 1'b0;
      word_reg      <= '0;
      wdata_reg     <= '0;
      read_data_reg <= '0;
      sram_addr_reg <= '0;
      dq_out_reg    <= '0;
      dq_oe_reg     <= 1'b0;
      we_n_reg      <= 1'b1;
      oe_n_reg      <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req) begin
            // A simultaneous load and store is treated as a store.
            op_wr_reg     <= mem.wr_en;
            word_reg      <= word_idx;
            wdata_reg     <= mem.write_data;
            cnt_reg       <= '0;
            state_reg     <= LOW;
            sram_addr_reg <= {word_idx, 1'b0};
            dq_out_reg    <= mem.wr_en ? mem.write_data[15:0] : 16'h0000;
            dq_oe_reg     <= mem.wr_en;
            we_n_reg      <= ~mem.wr_en;
            oe_n_reg      <= mem.wr_en;
          end
        end
        LOW: begin
          if (cnt_reg == CNT_LAST) begin
            if (!op_wr_reg) read_data_reg[15:0] <= sram_dq_in;
            cnt_reg       <= '0;
            state_reg     <= HIGH;
            sram_addr_reg <= {word_reg, 1'b1};
            dq_out_reg    <= op_wr_reg ? wdata_reg[31:16] : 16'h0000;
            we_n_reg      <= ~op_wr_reg;
          end else begin
            cnt_reg  <= cnt_inc;
            // WE rises one cycle before the phase ends so address/data outlast it.
            we_n_reg <= ~op_wr_reg | (cnt_inc == CNT_LAST);
          end
        end
        HIGH: begin
          if (cnt_reg == CNT_LAST) begin
            if (!op_wr_reg) read_data_reg[31:16] <= sram_dq_in;
            cnt_reg       <= '0;
            state_reg     <= DONE;
            sram_addr_reg <= '0;
            dq_out_reg    <= '0;
            dq_oe_reg     <= 1'b0;
            we_n_reg      <= 1'b1;
            oe_n_reg      <= 1'b1;
          end else begin
            cnt_reg  <= cnt_inc;
            we_n_reg <= ~op_wr_reg | (cnt_inc == CNT_LAST);
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign mem.ready     = ((state_reg == IDLE) && !req) || (state_reg == DONE);
  assign mem.read_data = read_data_reg;
  assign sram_addr     = sram_addr_reg;
  assign sram_dq_out   = dq_out_reg;
  assign sram_dq_oe    = dq_oe_reg;
  assign sram_we_n     = we_n_reg;
  assign sram_oe_n     = oe_n_reg;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: a table of back-to-back loads/stores against a
// small SRAM model, plus reset and mid-access reset sequences.
module tb_sram_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;
  logic        sram_we_n;
  logic        sram_oe_n;

  int tests = 0;
  int fails = 0;

  sram_controller_if bus ();

  sram_controller dut (
    .clk         (clk),
    .rst         (rst),
    .mem         (bus.slave),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_oe  (sram_dq_oe),
    .sram_dq_in  (sram_dq_in),
    .sram_we_n   (sram_we_n),
    .sram_oe_n   (sram_oe_n)
  );

  always #5 clk = ~clk;

  // Small SRAM model: writes while WE is low, reads combinationally while OE is low.
  logic [15:0] sram_mem [0:63];
  always @(posedge clk) begin
    if (!sram_we_n) sram_mem[sram_addr[5:0]] <= sram_dq_out;
  end
  assign sram_dq_in = sram_oe_n ? 16'h0000 : sram_mem[sram_addr[5:0]];

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic [17:0] exp_lo;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Presents one request in IDLE and checks every cycle up to DONE (cycle 5).
  task automatic run_txn(input int idx, input vec_t v);
    logic [17:0] exp_addr;
    logic        high;
    logic        first;
    int          fails_before;
    fails_before = fails;
    @(negedge clk);
    bus.wr_en      = v.wr;
    bus.rd_en      = v.rd;
    bus.address    = v.addr;
    bus.write_data = v.wdata;
    #1;
    check("ready_c0", 32'(bus.ready), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      // Garbage on the request lines mid-access must be ignored.
      bus.wr_en      = ~v.wr;
      bus.rd_en      = ~v.rd;
      bus.address    = v.addr ^ 32'h0000_0010;
      bus.write_data = ~v.wdata;
      #1;
      high     = (k >= 3);
      first    = (k == 1) || (k == 3);
      exp_addr = v.exp_lo | {17'd0, high};
      check("ready_busy", 32'(bus.ready), 32'd0);
      check("sram_addr", 32'(sram_addr), 32'(exp_addr));
      check("we_n", 32'(sram_we_n), v.wr ? 32'(!first) : 32'd1);
      check("oe_n", 32'(sram_oe_n), v.wr ? 32'd1 : 32'd0);
      check("dq_oe", 32'(sram_dq_oe), 32'(v.wr));
      if (v.wr) check("dq_out", 32'(sram_dq_out), high ? 32'(v.wdata[31:16]) : 32'(v.wdata[15:0]));
    end
    @(negedge clk);
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    #1;
    check("ready_done", 32'(bus.ready), 32'd1);
    check("read_data", bus.read_data, v.exp_rd);
    $display("[TB] txn %0d wr=%0b rd=%0b addr=%0d wdata=%h read_data=%h %s",
             idx, v.wr, v.rd, v.addr, v.wdata, bus.read_data,
             (fails == fails_before) ? "ok" : "bad");
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 32'd1032,   32'hDEADBEEF, 32'h00000000, 18'd4};
    vecs[1]  = '{1'b0, 1'b1, 32'd1032,   32'h00000000, 32'hDEADBEEF, 18'd4};
    vecs[2]  = '{1'b1, 1'b0, 32'd1024,   32'h12345678, 32'hDEADBEEF, 18'd0};
    vecs[3]  = '{1'b0, 1'b1, 32'd1024,   32'h00000000, 32'h12345678, 18'd0};
    vecs[4]  = '{1'b1, 1'b1, 32'd1024,   32'hCAFEF00D, 32'h12345678, 18'd0};
    vecs[5]  = '{1'b0, 1'b1, 32'd1024,   32'h00000000, 32'hCAFEF00D, 18'd0};
    vecs[6]  = '{1'b0, 1'b1, 32'd1032,   32'h00000000, 32'hDEADBEEF, 18'd4};
    vecs[7]  = '{1'b1, 1'b0, 32'd525320, 32'h0BADC0DE, 32'hDEADBEEF, 18'd4};
    vecs[8]  = '{1'b0, 1'b1, 32'd1032,   32'h00000000, 32'h0BADC0DE, 18'd4};
    vecs[9]  = '{1'b1, 1'b0, 32'd1020,   32'h11112222, 32'h0BADC0DE, 18'h3FFFE};
    vecs[10] = '{1'b0, 1'b1, 32'd1020,   32'h00000000, 32'h11112222, 18'h3FFFE};

    rst            = 1'b1;
    bus.wr_en      = 1'b0;
    bus.rd_en      = 1'b0;
    bus.address    = 32'd0;
    bus.write_data = 32'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_we_n", 32'(sram_we_n), 32'd1);
    check("rst_oe_n", 32'(sram_oe_n), 32'd1);
    check("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
    check("rst_read_data", bus.read_data, 32'd0);
    check("rst_sram_addr", 32'(sram_addr), 32'd0);
    $display("[TB] reset read_data=%h ready=%0b", bus.read_data, bus.ready);

    for (int i = 0; i < 11; i++) run_txn(i, vecs[i]);

    // Reset during the HIGH phase of a load.
    @(negedge clk);
    bus.rd_en   = 1'b1;
    bus.address = 32'd1032;
    @(negedge clk);
    bus.rd_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("midrst_ready", 32'(bus.ready), 32'd1);
    check("midrst_read_data", bus.read_data, 32'd0);
    check("midrst_oe_n", 32'(sram_oe_n), 32'd1);
    check("midrst_we_n", 32'(sram_we_n), 32'd1);
    check("midrst_dq_oe", 32'(sram_dq_oe), 32'd0);
    $display("[TB] mid-access reset read_data=%h ready=%0b", bus.read_data, bus.ready);
    rst = 1'b0;

    run_txn(11, '{1'b0, 1'b1, 32'd1032, 32'h00000000, 32'h0BADC0DE, 18'd4});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
